// File: rtl/mux_2_1_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux.
// A grant is held for at most MAX_HOLD cycles while the other side waits.
module mux_2_1_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             select,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] y,
  output logic             valid
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last;
  logic [CW-1:0] hold_cnt;
  logic          hold_full;

  assign hold_full = (hold_cnt == HOLD_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next == GNT_A && state != GNT_A) begin
        last <= 1'b0;
      end else if (state_next == GNT_B && state != GNT_B) begin
        last <= 1'b1;
      end
      if (state_next != state || state == IDLE) begin
        hold_cnt <= '0;
      end else if (!hold_full) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // A tie from IDLE goes to the side that was not served last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          state_next = last ? GNT_A : GNT_B;
        end else if (req_a) begin
          state_next = GNT_A;
        end else if (req_b) begin
          state_next = GNT_B;
        end
      end
      GNT_A: begin
        if (!req_a) begin
          state_next = req_b ? GNT_B : IDLE;
        end else if (req_b && hold_full) begin
          state_next = GNT_B;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_next = req_a ? GNT_A : IDLE;
        end else if (req_a && hold_full) begin
          state_next = GNT_A;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Data path lags the grant by one edge; y holds through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        GNT_A: begin
          y     <= a;
          valid <= 1'b1;
        end
        GNT_B: begin
          y     <= b;
          valid <= 1'b1;
        end
        default: valid <= 1'b0;
      endcase
    end
  end

  assign gnt_a  = (state == GNT_A);
  assign gnt_b  = (state == GNT_B);
  assign select = (state == GNT_B);

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Scoreboard bench for mux_2_1_arbiter (WIDTH=8, MAX_HOLD=4) using
// directed vectors with hand-computed per-cycle expectations.
module tb_mux_2_1_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic [7:0] a;
  logic [7:0] b;
  logic       select;
  logic       gnt_a;
  logic       gnt_b;
  logic [7:0] y;
  logic       valid;

  typedef struct packed {
    int         step;
    logic       ga;
    logic       gb;
    logic       sel;
    logic       v;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   passed;
  int   step_no;

  mux_2_1_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .req_b  (req_b),
    .a      (a),
    .b      (b),
    .select (select),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .y      (y),
    .valid  (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs just after a falling edge and queue what must be visible
  // after the following rising edge.
  task automatic applyStimulus(input logic r, input logic ra, input logic rb,
                               input logic [7:0] da, input logic [7:0] db,
                               input logic ega, input logic egb,
                               input logic ev, input logic [7:0] ey);
    exp_t e;
    @(negedge clk);
    #2;
    rst   = r;
    req_a = ra;
    req_b = rb;
    a     = da;
    b     = db;
    step_no++;
    e.step = step_no;
    e.ga   = ega;
    e.gb   = egb;
    e.sel  = egb;
    e.v    = ev;
    e.y    = ey;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (gnt_a === e.ga && gnt_b === e.gb && select === e.sel &&
        valid === e.v && y === e.y) begin
      passed++;
    end else begin
      $display("[TB] FAIL step%0d: got gnt_a=%b gnt_b=%b select=%b valid=%b y=%h, expected gnt_a=%b gnt_b=%b select=%b valid=%b y=%h",
               e.step, gnt_a, gnt_b, select, valid, y,
               e.ga, e.gb, e.sel, e.v, e.y);
    end
  endtask

  // Monitor: one expectation is consumed per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks  = 0;
    passed  = 0;
    step_no = 0;
    rst     = 1'b1;
    req_a   = 1'b0;
    req_b   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;

    // Reset, then A alone: grant after 1 edge, data after 2
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h11, 8'h00, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h11, 8'h00, 1, 0, 1, 8'h11);
    // Drop both while in GNT_A: IDLE, then valid falls and y holds
    applyStimulus(0, 0, 0, 8'h11, 8'h00, 0, 0, 1, 8'h11);
    applyStimulus(0, 0, 0, 8'h22, 8'h00, 0, 0, 0, 8'h11);

    // Simultaneous requests after reset: A first, then direct handover to B
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h33, 8'h44, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h33, 8'h44, 0, 1, 1, 8'h33);
    applyStimulus(0, 0, 1, 8'h33, 8'h44, 0, 1, 1, 8'h44);

    // Both held: four cycles per side
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 1, 0, 1, 8'h55);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 1, 0, 1, 8'h55);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 1, 0, 1, 8'h55);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 0, 1, 1, 8'h55);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 0, 1, 1, 8'h66);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 0, 1, 1, 8'h66);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 0, 1, 1, 8'h66);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 1, 0, 1, 8'h66);
    applyStimulus(0, 1, 1, 8'h55, 8'h66, 1, 0, 1, 8'h55);

    // A alone for 10 cycles saturates the counter; B then wins after 1 edge
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h77, 8'h00, 1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 0, 8'h77, 8'h00, 1, 0, 1, 8'h77);
    end
    applyStimulus(0, 1, 1, 8'h77, 8'h88, 0, 1, 1, 8'h77);
    applyStimulus(0, 1, 1, 8'h77, 8'h88, 0, 1, 1, 8'h88);

    // Reset mid-GNT_B clears everything; tie afterwards goes to A
    applyStimulus(1, 1, 1, 8'h99, 8'hAA, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h99, 8'hAA, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h99, 8'hAA, 0, 0, 1, 8'h99);
    applyStimulus(0, 0, 0, 8'h99, 8'hAA, 0, 0, 0, 8'h99);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
